// File: rtl/des_cmd_pkg.sv
// Shared definitions for the DES command initiator: command codes, host job
// opcodes and the sequencer state encoding.
package des_cmd_pkg;

  localparam logic [31:0] CmdReadRegion = 32'd0;
  localparam logic [31:0] CmdStart      = 32'd1;
  localparam logic [31:0] CmdTestMode   = 32'd2;
  localparam logic [31:0] CmdRestart    = 32'd3;

  typedef enum logic [1:0] {
    OpRun     = 2'd0,
    OpTest    = 2'd1,
    OpRestart = 2'd2,
    OpRsvd    = 2'd3
  } job_op_e;

  typedef enum logic [3:0] {
    StIdle, StRegReq, StRegRel, StStartReq, StStartRel, StWaitDone, StCapture, StTestReq,
    StTestRel, StTestWait, StTestCap, StAdv, StAdvGap, StRstReq, StRstRel, StFinish
  } state_e;

  // States in which the sequencer waits on the wrapper and the watchdog may fire.
  function automatic logic is_wait_state(state_e s);
    return s inside {StRegReq, StRegRel, StStartReq, StStartRel, StWaitDone, StTestReq,
                     StTestRel, StTestWait, StRstReq, StRstRel};
  endfunction

endpackage

// File: rtl/des_cmd_if.sv
// Command/result bus between the initiator (master) and the DES wrapper (slave).
interface des_cmd_if;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        advance_test_cmd;
  logic [31:0] region;
  logic        cmd_read;
  logic        test_res_ready;
  logic        done;
  logic [63:0] counter;
  logic [63:0] ciphertext;

  modport master (
    output cmd, cmd_valid, advance_test_cmd, region,
    input  cmd_read, test_res_ready, done, counter, ciphertext
  );

  modport slave (
    input  cmd, cmd_valid, advance_test_cmd, region,
    output cmd_read, test_res_ready, done, counter, ciphertext
  );
endinterface

// File: rtl/des_cmd_handshake.sv
// One 4-phase command exchange: REQ holds cmd_valid until cmd_read, REL waits for
// cmd_read to fall. cmd stays registered until the next start.
module des_cmd_handshake (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cmd_in,
  input  logic        cmd_read,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  output logic        granted,
  output logic        ack
);

  typedef enum logic [1:0] {HsIdle, HsReq, HsRel} hs_state_e;

  hs_state_e   state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic        load;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    load    = 1'b0;
    granted = (state_q == HsReq) && cmd_read;
    ack     = (state_q == HsRel) && !cmd_read;
    unique case (state_q)
      HsIdle: load = start;
      HsReq:  if (cmd_read) state_d = HsRel;
      HsRel: begin
        // A new exchange may begin in the same cycle the previous one releases.
        if (!cmd_read) begin
          state_d = HsIdle;
          load    = start;
        end
      end
      default: state_d = HsIdle;
    endcase
    if (load) begin
      state_d = HsReq;
      cmd_d   = cmd_in;
    end
    if (abort) state_d = HsIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HsIdle;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = (state_q == HsReq);

endmodule

// File: rtl/des_cmd_initiator.sv
// Host-job sequencer driving the DES wrapper command bus (RUN / TEST / RESTART).
// Define DES_CMD_TIMEOUT_EN to add the handshake watchdog.
module des_cmd_initiator
  import des_cmd_pkg::*;
#(
  parameter int unsigned ADV_HOLD       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [1:0]  job_op,
  input  logic [15:0] job_region,
  input  logic [7:0]  job_steps,
  output logic        result_valid,
  output logic [63:0] result_counter,
  output logic [63:0] result_ciphertext,
  output logic        job_done,
  output logic        job_err,
  des_cmd_if.master   des
);

  localparam logic [15:0] AdvLast = 16'(ADV_HOLD - 1);

  if (ADV_HOLD < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("des_cmd_initiator: ADV_HOLD must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  state_e      state_q, state_d;
  job_op_e     op_q, op_d;
  logic [15:0] region_q, region_d;
  logic [7:0]  steps_q, steps_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        capture, hs_start, hs_abort, hs_granted, hs_ack;
  logic [31:0] hs_cmd;
  logic        result_valid_q;
  logic [63:0] result_counter_q, result_ciphertext_q;

`ifdef DES_CMD_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            timeout;

  assign timeout = is_wait_state(state_q) && (tmr_q == TmrLast);
  // Restarts on every state entry, so each wait phase gets the full budget.
  assign tmr_d   = (state_d != state_q || !is_wait_state(state_q)) ? '0 : tmr_q + TmrW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    region_d = region_q;
    steps_d  = steps_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    capture  = 1'b0;
    hs_start = 1'b0;
    hs_abort = 1'b0;
    hs_cmd   = CmdReadRegion;
    unique case (state_q)
      StIdle: begin
        if (job_valid) begin
          op_d     = job_op_e'(job_op);
          region_d = job_region;
          steps_d  = (job_steps == 8'd0) ? 8'd1 : job_steps;
          err_d    = 1'b0;
          case (job_op_e'(job_op))
            OpRun, OpTest: begin
              state_d  = StRegReq;
              hs_start = 1'b1;
            end
            OpRestart: begin
              state_d  = StRstReq;
              hs_start = 1'b1;
              hs_cmd   = CmdRestart;
            end
            default: begin
              state_d = StFinish;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StRegReq:   if (hs_granted) state_d = StRegRel;
      StRegRel: begin
        if (hs_ack) begin
          hs_start = 1'b1;
          if (op_q == OpTest) begin
            state_d = StTestReq;
            hs_cmd  = CmdTestMode;
          end else begin
            state_d = StStartReq;
            hs_cmd  = CmdStart;
          end
        end
      end
      StStartReq: if (hs_granted) state_d = StStartRel;
      StStartRel: if (hs_ack) state_d = StWaitDone;
      StWaitDone: if (des.done) state_d = StCapture;
      StCapture: begin
        capture  = 1'b1;
        state_d  = StRstReq;
        hs_start = 1'b1;
        hs_cmd   = CmdRestart;
      end
      StTestReq:  if (hs_granted) state_d = StTestRel;
      StTestRel:  if (hs_ack) state_d = StTestWait;
      StTestWait: if (des.test_res_ready) state_d = StTestCap;
      StTestCap: begin
        capture = 1'b1;
        if (steps_q == 8'd1) begin
          state_d  = StRstReq;
          hs_start = 1'b1;
          hs_cmd   = CmdRestart;
        end else begin
          steps_d = steps_q - 8'd1;
          state_d = StAdv;
        end
      end
      StAdv: begin
        if (cnt_q == AdvLast) state_d = StAdvGap;
        else                  cnt_d   = cnt_q + 16'd1;
      end
      StAdvGap: begin
        if (cnt_q == 16'd1) state_d = StTestWait;
        else                cnt_d   = cnt_q + 16'd1;
      end
      StRstReq:   if (hs_granted) state_d = StRstRel;
      StRstRel:   if (hs_ack) state_d = StFinish;
      StFinish:   state_d = StIdle;
    endcase
`ifdef DES_CMD_TIMEOUT_EN
    if (timeout) begin
      state_d  = StFinish;
      err_d    = 1'b1;
      hs_start = 1'b0;
      hs_abort = 1'b1;
    end
`endif
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= StIdle;
      op_q                <= OpRun;
      region_q            <= '0;
      steps_q             <= '0;
      cnt_q               <= '0;
      err_q               <= 1'b0;
      result_valid_q      <= 1'b0;
      result_counter_q    <= '0;
      result_ciphertext_q <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      region_q       <= region_d;
      steps_q        <= steps_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      result_valid_q <= capture;
      if (capture) begin
        result_counter_q    <= des.counter;
        result_ciphertext_q <= des.ciphertext;
      end
    end
  end

  des_cmd_handshake u_hs (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (hs_start),
    .abort     (hs_abort),
    .cmd_in    (hs_cmd),
    .cmd_read  (des.cmd_read),
    .cmd       (des.cmd),
    .cmd_valid (des.cmd_valid),
    .granted   (hs_granted),
    .ack       (hs_ack)
  );

  assign job_ready            = (state_q == StIdle);
  assign job_done             = (state_q == StFinish);
  assign job_err              = job_done && err_q;
  assign result_valid         = result_valid_q;
  assign result_counter       = result_counter_q;
  assign result_ciphertext    = result_ciphertext_q;
  assign des.advance_test_cmd = (state_q == StAdv);
  assign des.region           = {16'h0000, region_q};

endmodule

// File: tb/tb_des_cmd_initiator.sv
// Directed bench for des_cmd_initiator with a reactive DES wrapper model.
module tb_des_cmd_initiator;

  localparam logic [63:0] RunCnt = 64'hDEAD_BEEF_0000_0050;
  localparam logic [63:0] RunCt  = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [1:0]  job_op = 2'd0;
  logic [15:0] job_region = 16'h0;
  logic [7:0]  job_steps = 8'h0;
  logic        result_valid;
  logic [63:0] result_counter, result_ciphertext;
  logic        job_done, job_err;
  logic        withhold = 1'b0;

  des_cmd_if bus ();

  des_cmd_initiator #(
    .ADV_HOLD       (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_op            (job_op),
    .job_region        (job_region),
    .job_steps         (job_steps),
    .result_valid      (result_valid),
    .result_counter    (result_counter),
    .result_ciphertext (result_ciphertext),
    .job_done          (job_done),
    .job_err           (job_err),
    .des               (bus)
  );

  always #5 clk = ~clk;

  // Wrapper model: acks commands a cycle late, raises done 50 cycles after START,
  // produces a test result 5 cycles after TEST_MODE / each advance; data lags flags by 1.
  logic m_cvp, m_donep, m_trrp, m_advp;
  int   run_cd, test_cd, step_idx;
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.cmd_read <= 1'b0; bus.done <= 1'b0; bus.test_res_ready <= 1'b0;
      bus.counter <= '0; bus.ciphertext <= '0;
      m_cvp <= 1'b0; m_donep <= 1'b0; m_trrp <= 1'b0; m_advp <= 1'b0;
      run_cd <= 0; test_cd <= 0; step_idx <= 0;
    end else begin
      bus.cmd_read <= bus.cmd_valid && !withhold;
      m_cvp <= bus.cmd_valid; m_donep <= bus.done;
      m_trrp <= bus.test_res_ready; m_advp <= bus.advance_test_cmd;
      if (bus.cmd_valid && !m_cvp) begin
        case (bus.cmd)
          32'd1: run_cd <= 50;
          32'd2: begin test_cd <= 5; step_idx <= 0; end
          32'd3: begin bus.done <= 1'b0; bus.test_res_ready <= 1'b0; end
          default: ;
        endcase
      end
      if (run_cd != 0) begin
        run_cd <= run_cd - 1;
        if (run_cd == 1) bus.done <= 1'b1;
      end
      if (m_advp && !bus.advance_test_cmd) test_cd <= 5;
      if (test_cd != 0) begin
        test_cd <= test_cd - 1;
        if (test_cd == 1) begin bus.test_res_ready <= 1'b1; step_idx <= step_idx + 1; end
      end
      if (bus.advance_test_cmd) bus.test_res_ready <= 1'b0;
      if (bus.done && !m_donep) begin bus.counter <= RunCnt; bus.ciphertext <= RunCt; end
      if (bus.test_res_ready && !m_trrp) begin
        bus.counter    <= 64'hA000 + 64'(step_idx);
        bus.ciphertext <= 64'hB000 + 64'(step_idx);
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [31:0] log_cmd [64];
  logic [63:0] rv_cnt [64];
  logic [63:0] rv_ct [64];
  int          adv_w [64];
  int          log_n = 0, rv_n = 0, adv_n = 0, adv_cur = 0, done_n = 0, both_n = 0, cv_cycles = 0;
  logic        cv_prev = 1'b0, last_err = 1'b0;
  always @(negedge clk) begin
    if (bus.cmd_valid && !cv_prev) begin log_cmd[log_n & 63] = bus.cmd; log_n++; end
    cv_prev = bus.cmd_valid;
    if (bus.cmd_valid) cv_cycles++;
    if (bus.cmd_valid && bus.advance_test_cmd) both_n++;
    if (result_valid) begin
      rv_cnt[rv_n & 63] = result_counter; rv_ct[rv_n & 63] = result_ciphertext; rv_n++;
    end
    if (bus.advance_test_cmd) adv_cur++;
    else if (adv_cur > 0) begin adv_w[adv_n & 63] = adv_cur; adv_n++; adv_cur = 0; end
    if (job_done) begin done_n++; last_err = job_err; end
  end

  int n_cmp = 0, n_fail = 0;
  int b_log, b_rv, b_adv, b_done, b_cv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_log = log_n; b_rv = rv_n; b_adv = adv_n; b_done = done_n; b_cv = cv_cycles;
  endtask

  task automatic submit(input logic [1:0] op, input logic [15:0] rg, input logic [7:0] st);
    step();
    check("ready_before_job", {63'h0, job_ready}, 64'h1);
    job_valid = 1'b1; job_op = op; job_region = rg; job_steps = st;
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (done_n == b_done && k < limit) begin step(); k++; end
    check(tag, 64'(done_n - b_done), 64'h1);
  endtask

  initial begin
    repeat (3) step();
    check("rst_cmd_valid", {63'h0, bus.cmd_valid}, 64'h0);
    check("rst_cmd", {32'h0, bus.cmd}, 64'h0);
    check("rst_region", {32'h0, bus.region}, 64'h0);
    check("rst_result_valid", {63'h0, result_valid}, 64'h0);
    check("rst_result_counter", result_counter, 64'h0);
    check("rst_job_done", {63'h0, job_done}, 64'h0);
    rst_n = 1'b1;
    step();
    check("ready_after_release", {63'h0, job_ready}, 64'h1);

    // RUN, with a stray request while busy that must be ignored
    snap();
    submit(2'd0, 16'h00A5, 8'd0);
    check("run_region", {32'h0, bus.region}, 64'h0000_00A5);
    job_valid = 1'b1; job_op = 2'd3;
    repeat (3) step();
    job_valid = 1'b0;
    wait_done("run_done", 300);
    check("run_err", {63'h0, last_err}, 64'h0);
    check("run_ncmd", 64'(log_n - b_log), 64'd3);
    check("run_cmd0", {32'h0, log_cmd[b_log & 63]}, 64'd0);
    check("run_cmd1", {32'h0, log_cmd[(b_log + 1) & 63]}, 64'd1);
    check("run_cmd2", {32'h0, log_cmd[(b_log + 2) & 63]}, 64'd3);
    check("run_nres", 64'(rv_n - b_rv), 64'd1);
    check("run_counter", rv_cnt[b_rv & 63], RunCnt);
    check("run_cipher", rv_ct[b_rv & 63], RunCt);

    // TEST, three steps
    snap();
    submit(2'd1, 16'h1234, 8'd3);
    wait_done("test3_done", 400);
    check("test3_err", {63'h0, last_err}, 64'h0);
    check("test3_ncmd", 64'(log_n - b_log), 64'd3);
    check("test3_cmd0", {32'h0, log_cmd[b_log & 63]}, 64'd0);
    check("test3_cmd1", {32'h0, log_cmd[(b_log + 1) & 63]}, 64'd2);
    check("test3_cmd2", {32'h0, log_cmd[(b_log + 2) & 63]}, 64'd3);
    check("test3_nres", 64'(rv_n - b_rv), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("test3_counter", rv_cnt[(b_rv + i) & 63], 64'hA001 + 64'(i));
      check("test3_cipher", rv_ct[(b_rv + i) & 63], 64'hB001 + 64'(i));
    end
    check("test3_nadv", 64'(adv_n - b_adv), 64'd2);
    check("test3_adv_w0", 64'(adv_w[b_adv & 63]), 64'd2);
    check("test3_adv_w1", 64'(adv_w[(b_adv + 1) & 63]), 64'd2);

    // TEST with steps=0 behaves as one step
    snap();
    submit(2'd1, 16'h0001, 8'd0);
    wait_done("test0_done", 300);
    check("test0_nres", 64'(rv_n - b_rv), 64'd1);
    check("test0_counter", rv_cnt[b_rv & 63], 64'hA001);
    check("test0_nadv", 64'(adv_n - b_adv), 64'd0);

    // RESTART alone
    snap();
    submit(2'd2, 16'h0002, 8'd0);
    wait_done("rst_job_done", 100);
    check("rst_job_err", {63'h0, last_err}, 64'h0);
    check("rst_job_ncmd", 64'(log_n - b_log), 64'd1);
    check("rst_job_cmd", {32'h0, log_cmd[b_log & 63]}, 64'd3);
    check("rst_job_nres", 64'(rv_n - b_rv), 64'd0);

    // Reserved op
    snap();
    submit(2'd3, 16'h0003, 8'd0);
    wait_done("rsvd_done", 1);
    check("rsvd_err", {63'h0, last_err}, 64'h1);
    check("rsvd_no_cmd", 64'(cv_cycles - b_cv), 64'd0);

    check("never_both_high", 64'(both_n), 64'd0);

`ifdef DES_CMD_TIMEOUT_EN
    snap();
    withhold = 1'b1;
    submit(2'd0, 16'h0004, 8'd0);
    begin
      int k;
      k = 0;
      while (done_n == b_done && k < 40) begin step(); k++; end
      check("tmo_done", 64'(done_n - b_done), 64'h1);
      check("tmo_cycle", 64'(k), 64'd16);
      check("tmo_err", {63'h0, last_err}, 64'h1);
      check("tmo_cmd_valid", {63'h0, bus.cmd_valid}, 64'h0);
    end
    withhold = 1'b0;
    repeat (3) step();
`endif

    // Reset during WAIT_DONE
    snap();
    submit(2'd0, 16'h00A5, 8'd0);
    begin
      int k;
      k = 0;
      while (log_n - b_log < 2 && k < 50) begin step(); k++; end
      check("wd_start_seen", 64'(log_n - b_log), 64'd2);
    end
    repeat (10) step();
    rst_n = 1'b0;
    step();
    check("wd_rst_cmd_valid", {63'h0, bus.cmd_valid}, 64'h0);
    check("wd_rst_adv", {63'h0, bus.advance_test_cmd}, 64'h0);
    check("wd_rst_result_valid", {63'h0, result_valid}, 64'h0);
    check("wd_rst_job_done", {63'h0, job_done}, 64'h0);
    check("wd_rst_job_err", {63'h0, job_err}, 64'h0);
    check("wd_rst_cmd", {32'h0, bus.cmd}, 64'h0);
    check("wd_rst_region", {32'h0, bus.region}, 64'h0);
    check("wd_rst_counter", result_counter, 64'h0);
    check("wd_rst_cipher", result_ciphertext, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("wd_ready_after_release", {63'h0, job_ready}, 64'h1);
    repeat (80) step();
    check("wd_no_done", 64'(done_n - b_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/des_cmd_initiator.md
DES_CMD_INITIATOR -- requirements
Module: des_cmd_initiator

Interface
REQ-001 SHALL have parameter ADV_HOLD, default 2, cycles advance_test_cmd is held high per test step (min 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, handshake watchdog limit (used only with DES_CMD_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port job_valid  in  1  host job request.
REQ-006 SHALL have port job_ready  out  1  high in IDLE only; a job is accepted when job_valid and job_ready are both high.
REQ-007 SHALL have port job_op  in  2  0=RUN, 1=TEST, 2=RESTART, 3=reserved (accepted, done immediately, err=1).
REQ-008 SHALL have port job_region  in  16  DES region select.
REQ-009 SHALL have port job_steps  in  8  TEST result count; 0 treated as 1.
REQ-010 SHALL have port result_valid  out  1  one-cycle pulse per captured result; no backpressure.
REQ-011 SHALL have port result_counter  out  64  captured counter.
REQ-012 SHALL have port result_ciphertext  out  64  captured ciphertext.
REQ-013 SHALL have port job_done  out  1  one-cycle pulse at job end.
REQ-014 SHALL have port job_err  out  1  valid with job_done; 1 = timeout or reserved op.
REQ-015 SHALL have ports cmd out 32, cmd_valid out 1, advance_test_cmd out 1, region out 32 (bits 31:16 zero), toward the DES wrapper.
REQ-016 SHALL have ports cmd_read in 1, test_res_ready in 1, done in 1, counter in 64, ciphertext in 64, from the DES wrapper.

Function
REQ-017 Command codes SHALL be READ_REGION=0, START=1, TEST_MODE=2, RESTART=3.
REQ-018 Each command SHALL use a 4-phase handshake: REQ drives cmd and cmd_valid=1 until cmd_read=1; REL drives cmd_valid=0 until cmd_read=0.
REQ-019 cmd SHALL be held stable from REQ entry to REL exit; region SHALL be the job_region latched at acceptance, held for the whole job.
REQ-020 States SHALL be IDLE, REG_REQ, REG_REL, START_REQ, START_REL, WAIT_DONE, CAPTURE, TEST_REQ, TEST_REL, TEST_WAIT, TEST_CAP, ADV, ADV_GAP, RST_REQ, RST_REL, FINISH.
REQ-021 RUN SHALL sequence REG handshake, START handshake, WAIT_DONE, then CAPTURE, RST handshake, FINISH.
REQ-022 CAPTURE SHALL be entered on the first cycle done=1; counter and ciphertext SHALL be sampled on the following cycle (wrapper register latency), with result_valid pulsed that same cycle.
REQ-023 TEST SHALL sequence REG handshake, TEST handshake, then loop: TEST_WAIT until test_res_ready=1; TEST_CAP samples counter/ciphertext one cycle later and pulses result_valid.
REQ-024 After each TEST capture other than the last, the block SHALL hold advance_test_cmd=1 for exactly ADV_HOLD cycles (ADV), then 0 for at least 2 cycles (ADV_GAP) before returning to TEST_WAIT.
REQ-025 After job_steps captures, TEST SHALL perform the RST handshake, then FINISH.
REQ-026 RESTART SHALL perform the RST handshake only, then FINISH.
REQ-027 FINISH SHALL pulse job_done for one cycle and return to IDLE; job_ready SHALL rise the cycle after.
REQ-028 job_valid while not in IDLE SHALL be ignored.
REQ-029 advance_test_cmd and cmd_valid SHALL never be high in the same cycle.
REQ-030 The step counter SHALL be 8-bit, decrementing, and compared against 1 (no wrap-around).

Reset
REQ-031 When rst_n=0 at a clock edge, the state SHALL become IDLE and cmd_valid, advance_test_cmd, result_valid, job_done, job_err SHALL be 0; cmd, region, result_counter, result_ciphertext SHALL be 0; job_ready SHALL be 1 the cycle after release.
REQ-032 Reset mid-job SHALL abandon the job with no job_done; the host re-synchronises the wrapper through its shared rst_n.

Configuration
REQ-033 With DES_CMD_TIMEOUT_EN defined, a counter SHALL restart on every entry to REQ/REL/WAIT_DONE/TEST_WAIT states; reaching TIMEOUT_CYCLES SHALL drop cmd_valid and advance_test_cmd, pulse job_done with job_err=1, and return to IDLE.
REQ-034 Without DES_CMD_TIMEOUT_EN, no watchdog logic SHALL exist; waits are unbounded and job_err is set only by reserved op.

Structure
REQ-035 Package des_cmd_pkg SHALL hold the command codes, job_op encodings and the state enum.
REQ-036 One sub-module des_cmd_handshake SHALL implement a single REQ/REL exchange (start, cmd in; cmd/cmd_valid out; ack pulse).

Verification
REQ-037 RUN region=0x00A5, wrapper model done after 50 cycles -> cmd sequence 0,1,3; one result_valid with counter=model value; job_done, job_err=0.
REQ-038 TEST steps=3 -> TEST_MODE issued; 3 result_valid pulses; exactly 2 advance pulses each ADV_HOLD=2 cycles wide; then RESTART; job_done.
REQ-039 RESTART alone while wrapper in finishing -> single cmd=3 handshake; job_done, no result_valid.
REQ-040 Model withholds cmd_read with DES_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16 -> cmd_valid drops, job_done with job_err=1 at cycle 16.
REQ-041 Reset asserted during WAIT_DONE -> all outputs 0 next cycle, job_ready=1 after release, no job_done.
REQ-042 job_op=3 -> job_done with job_err=1 within 2 cycles, cmd_valid never asserted.
